// File: rtl/seg_scan_if.sv
// Load handshake and multiplexed-display bus for the digit scan controller.
// The master drives control and load data; the slave (controller) drives the display strobes.
interface seg_scan_if #(
  parameter int N_DIGITS = 4
);
  logic                    enable;
  logic                    lzb_en;
  logic                    load_valid;
  logic [4*N_DIGITS-1:0]   load_data;
  logic                    load_ready;
  logic [3:0]              bcd;
  logic [N_DIGITS-1:0]     digit_sel;
  logic                    frame_tick;

  modport master (
    output enable, lzb_en, load_valid, load_data,
    input  load_ready, bcd, digit_sel, frame_tick
  );

  modport slave (
    input  enable, lzb_en, load_valid, load_data,
    output load_ready, bcd, digit_sel, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed BCD display scanner: blank gap, then dwell on each digit in turn.
// New values are double-buffered so a frame always shows a single consistent value.
module seg_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(N_DIGITS);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] disp;
  logic [4*N_DIGITS-1:0] pend;
  logic                  pfull;
  logic                  xfer;
  logic                  boundary;
  logic                  pfull_nx;

  // Digit k is suppressed when it and every more significant nibble are zero; digit 0 always shows.
  function automatic logic [3:0] show_nibble(input logic [4*N_DIGITS-1:0] d,
                                             input logic [IDX_W-1:0]      k,
                                             input logic                  lzb);
    logic lead;
    lead = 1'b1;
    for (int j = 0; j < N_DIGITS; j++)
      if (j >= int'(k) && d[4*j +: 4] != 4'h0) lead = 1'b0;
    if (lzb && k != '0 && lead) return 4'hF;
    return d[4*int'(k) +: 4];
  endfunction

  assign xfer     = bus.load_valid & bus.load_ready;
  assign boundary = bus.enable && state == SHOW && cnt == '0 && idx == IDX_W'(N_DIGITS - 1);

  always_comb begin
    pfull_nx = pfull;
    if (boundary)                pfull_nx = 1'b0;
    if (xfer && state != IDLE)   pfull_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      disp           <= '0;
      pend           <= '0;
      pfull          <= 1'b0;
      bus.digit_sel  <= '0;
      bus.bcd        <= 4'hF;
      bus.frame_tick <= 1'b0;
      bus.load_ready <= 1'b0;
    end else begin
      bus.frame_tick <= 1'b0;
      pfull          <= pfull_nx;
      // A boundary copy only happens with pending full, which keeps load_ready low, so it never meets a transfer.
      if (xfer && state == IDLE) disp <= bus.load_data;
      if (xfer && state != IDLE) pend <= bus.load_data;
      if (boundary && pfull)     disp <= pend;

      if (!bus.enable) begin
        state          <= IDLE;
        cnt            <= '0;
        idx            <= '0;
        bus.digit_sel  <= '0;
        bus.bcd        <= 4'hF;
        bus.load_ready <= 1'b1;
      end else begin
        bus.load_ready <= !pfull_nx;
        case (state)
          IDLE: begin
            state <= BLANK;
            cnt   <= CNT_W'(BLANK_CYCLES - 1);
          end
          BLANK: begin
            if (cnt == '0) begin
              state         <= SHOW;
              cnt           <= CNT_W'(DWELL_CYCLES - 1);
              bus.digit_sel <= N_DIGITS'(1) << idx;
              bus.bcd       <= show_nibble(disp, idx, bus.lzb_en);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          SHOW: begin
            if (cnt == '0) begin
              state         <= BLANK;
              cnt           <= CNT_W'(BLANK_CYCLES - 1);
              bus.digit_sel <= '0;
              bus.bcd       <= 4'hF;
              if (idx == IDX_W'(N_DIGITS - 1)) begin
                idx            <= '0;
                bus.frame_tick <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt     <= cnt - 1'b1;
              bus.bcd <= show_nibble(disp, idx, bus.lzb_en);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position model predicts every cycle's outputs,
// a separate monitor compares them on the falling edge.
module tb_seg_scan_ctrl;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int B  = 2;
  localparam int SL = B + D;
  localparam int F  = N * SL;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_if #(.N_DIGITS(N)) bus ();

  seg_scan_ctrl #(.N_DIGITS(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [N-1:0] ds;
    logic [3:0]   bcd;
    logic         ft;
    logic         lr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: position inside the frame, display/pending values, pending flag.
  bit          m_scan  = 0;
  int          m_t     = 0;
  logic [15:0] m_disp  = '0;
  logic [15:0] m_pend  = '0;
  bit          m_pfull = 0;
  bit          m_lr    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic exp_t view(input bit tick, input bit lzb);
    exp_t e;
    int   slot, pos;
    e.ds = '0; e.bcd = 4'hF; e.ft = tick; e.lr = m_lr;
    if (m_scan) begin
      slot = m_t / SL;
      pos  = m_t % SL;
      if (pos >= B) begin
        e.ds  = N'(1) << slot;
        e.bcd = m_disp[4*slot +: 4];
        if (lzb && slot > 0 && (m_disp >> (4*slot)) == 16'h0) e.bcd = 4'hF;
      end
    end
    return e;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      begin
        exp_t e;
        bit   tick;
        bit   xfer;
        tick = 0;
        if (!rst_n) begin
          m_scan = 0; m_t = 0; m_disp = '0; m_pend = '0; m_pfull = 0; m_lr = 0;
          e = '{ds: '0, bcd: 4'hF, ft: 1'b0, lr: 1'b0};
        end else begin
          xfer = bus.load_valid && m_lr;
          if (!m_scan) begin
            if (xfer) m_disp = bus.load_data;
            if (bus.enable) begin m_scan = 1; m_t = 0; end
          end else begin
            if (!bus.enable) m_scan = 0;
            else begin
              m_t++;
              if (m_t == F) begin
                m_t  = 0;
                tick = 1;
                if (m_pfull) begin m_disp = m_pend; m_pfull = 0; end
              end
            end
            if (xfer) begin m_pend = bus.load_data; m_pfull = 1; end
          end
          m_lr = m_scan ? !m_pfull : 1'b1;
          e = view(tick, bus.lzb_en);
        end
        q.push_back(e);
      end
    end
  end

  // Monitor: outputs are registered, so compare one expectation per cycle at the falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (!rst_n) e = '{ds: '0, bcd: 4'hF, ft: 1'b0, lr: 1'b0};
        chk("digit_sel",  32'(bus.digit_sel),  32'(e.ds));
        chk("bcd",        32'(bus.bcd),        32'(e.bcd));
        chk("frame_tick", 32'(bus.frame_tick), 32'(e.ft));
        chk("load_ready", 32'(bus.load_ready), 32'(e.lr));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input logic [15:0] data);
    bit done;
    done = 0;
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    for (int i = 0; i < 3*F && !done; i++) begin
      if (bus.load_ready) done = 1;
      @(negedge clk);
    end
    bus.load_valid = 1'b0;
    if (!done) chk("load_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_sel(input logic [N-1:0] sel);
    bit seen;
    seen = 0;
    for (int i = 0; i < 2*F && !seen; i++) begin
      @(negedge clk);
      if (bus.digit_sel == sel) seen = 1;
    end
    if (!seen) chk("digit_sel_wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bus.enable = 1'b0; bus.lzb_en = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    offer(16'h1234);
    bus.enable = 1'b1;
    cyc(2*F);
    cyc(5);
    offer(16'h5678);
    cyc(2*F);

    bus.lzb_en = 1'b1;
    offer(16'h0040);
    cyc(2*F);
    offer(16'h0000);
    cyc(2*F);

    wait_sel(4'b0100);
    bus.enable = 1'b0;
    cyc(4);
    bus.enable = 1'b1;
    cyc(F + 3);

    bus.load_valid = 1'b1;
    for (int i = 0; i < 4*F; i++) begin
      bus.load_data = 16'($urandom);
      @(negedge clk);
    end
    bus.load_valid = 1'b0;
    cyc(F);

    offer(16'h9876);
    wait_sel(4'b0010);
    @(posedge clk);
    #2 rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    bus.lzb_en = 1'b0;
    cyc(F + 4);

    for (int i = 0; i < 1500; i++) begin
      logic [15:0] d;
      for (int k = 0; k < N; k++) d[4*k +: 4] = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom);
      bus.enable     = ($urandom % 60) != 0;
      bus.load_valid = ($urandom % 4) == 0;
      bus.load_data  = d;
      if ($urandom % 100 == 0) bus.lzb_en = ~bus.lzb_en;
      @(negedge clk);
    end
    bus.enable = 1'b0;
    bus.load_valid = 1'b0;
    cyc(3);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter DWELL_CYCLES, default 50000: clock cycles each digit is driven, minimum 1.
REQ-003 Parameter BLANK_CYCLES, default 500: anti-ghosting gap before each digit, minimum 1.
REQ-004 clk  in  1: single clock; all state updates on rising edge.
REQ-005 rst_n  in  1: reset, asynchronous assert, active-low.
REQ-006 enable  in  1: scan enable; low forces IDLE.
REQ-007 lzb_en  in  1: leading-zero blanking enable.
REQ-008 load_valid  in  1: new display value offered.
REQ-009 load_data  in  4*N_DIGITS: BCD nibbles; nibble i drives digit i; digit N_DIGITS-1 is most significant.
REQ-010 load_ready  out  1: controller accepts load_data this cycle.
REQ-011 bcd  out  4: nibble fed to the shared BCD-to-7-segment decoder; 4'hF means blank.
REQ-012 digit_sel  out  N_DIGITS: one-hot active-high digit strobe; all-zero when nothing is driven.
REQ-013 frame_tick  out  1: one-cycle pulse at end of each full scan frame.

Function
REQ-014 Outputs bcd, digit_sel, frame_tick and load_ready are registered.
REQ-015 FSM states: IDLE, BLANK, SHOW; one down-counter is shared between BLANK and SHOW; a digit index idx runs 0..N_DIGITS-1.
REQ-016 IDLE: digit_sel=0, bcd=4'hF, idx=0, counter cleared; leaves to BLANK on the first edge that samples enable=1.
REQ-017 BLANK: lasts exactly BLANK_CYCLES cycles; digit_sel=0, bcd=4'hF; then goes to SHOW.
REQ-018 SHOW: lasts exactly DWELL_CYCLES cycles; digit_sel has only bit idx set; bcd = display nibble idx, or 4'hF when that digit is leading-zero blanked.
REQ-019 At the end of SHOW with idx<N_DIGITS-1: idx increments and the FSM goes to BLANK.
REQ-020 At the end of SHOW with idx=N_DIGITS-1: idx wraps to 0, the FSM goes to BLANK, and frame_tick is 1 for exactly one cycle.
REQ-021 Frame length is N_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
REQ-022 enable sampled low in any state: the next state is IDLE and outputs take IDLE values the following cycle; no frame_tick is generated.
REQ-023 Storage: display register (the value being shown) plus pending register with a pending_full flag.
REQ-024 load_ready=1 in IDLE; otherwise load_ready=!pending_full.
REQ-025 Transfer occurs when load_valid & load_ready are both high.
REQ-026 A transfer in IDLE writes the display register directly; it is shown from the next frame start.
REQ-027 A transfer outside IDLE writes the pending register and sets pending_full.
REQ-028 At a frame boundary (REQ-020 cycle) with pending_full: the display register takes the pending value and pending_full clears.
REQ-029 Displayed content never changes mid-frame.
REQ-030 Leading-zero blanking when lzb_en=1: digit k is blanked when every nibble from N_DIGITS-1 down to k is 4'h0.
REQ-031 Digit 0 is never blanked by leading-zero blanking.
REQ-032 lzb_en is evaluated against the display register during SHOW.
REQ-033 Nibbles 4'hA..4'hF pass through unchanged; the decoder blanks them.
REQ-034 pending_full and the pending register are retained across an enable drop; leaving IDLE does not discard pending data.

Reset
REQ-035 While rst_n=0: state=IDLE, idx=0, counter=0, display register=0, pending register=0, pending_full=0, digit_sel=0, bcd=4'hF, frame_tick=0, load_ready=0.
REQ-036 On the first edge after rst_n rises, load_ready becomes 1.
REQ-037 Reset asserted mid-frame takes effect immediately and asynchronously; all scan and pending state is lost.

Verification (N_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2)
REQ-038 Load 16'h1234 in IDLE, then enable=1 -> per 6-cycle slot: 2 cycles digit_sel=0000 with bcd=F, then 4 cycles digit_sel=0001/0010/0100/1000 with bcd=4/3/2/1; frame_tick pulses every 24 cycles.
REQ-039 While scanning, offer 16'h5678 mid-frame -> accepted; load_ready=0 until the frame boundary; the current frame still shows 1234 and the next frame shows 5678.
REQ-040 lzb_en=1, display 16'h0040 -> digits 3 and 2 get bcd=F, digit 1 gets 4, digit 0 gets 0; display 16'h0000 -> only digit 0 shows 0.
REQ-041 Drop enable during SHOW of digit 2 -> the next cycle digit_sel=0, bcd=F, with no frame_tick; on re-enable, scanning restarts at BLANK before digit 0.
REQ-042 Assert rst_n=0 mid-SHOW with pending_full=1 -> outputs take their reset values immediately; after release load_ready=1 and the display register is 0.
REQ-043 Hold load_valid=1 continuously while scanning -> exactly one transfer per frame, each at the cycle following the frame_tick boundary.
